uart_frame_parser: RTL

- Clocked, parametrised successor to the receive-side frame buffer.
- Takes bytes from the UART receiver on a `recieve` strobe and frames them as PAYLOAD_BYTES payload bytes followed by a two-byte terminator (default 0D 0A).
- On each good frame it publishes the payload and pulses `frame_valid`. Last good payload is held, never overwritten with filler. Framing and checksum errors are flagged and counted.

---
 rtl/uart_frame_parser.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Frames bytes from a UART receiver into fixed-length payloads closed by a two-byte terminator.
// Publishes the last good payload, pulses valid/error, and keeps saturating frame/error counts.
module uart_frame_parser #(
  parameter int           PAYLOAD_BYTES = 3,
  parameter logic [7:0]   TERM_HI       = 8'h0D,
  parameter logic [7:0]   TERM_LO       = 8'h0A,
  parameter bit           CHECKSUM_EN   = 1'b0,
  parameter int           CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       recieve,
  input  logic [7:0]                 data,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic                       synced,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  // state   | meaning
  // HUNT    | looking for a TERM_HI,TERM_LO pair to align on
  // COLLECT | writing payload bytes into the shadow buffer
  // EXP_HI  | payload complete, expecting TERM_HI
  // EXP_LF  | expecting TERM_LO, then commit or flag error
  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EXP_HI  = 2'd2;
  localparam logic [1:0] EXP_LF  = 2'd3;

  localparam int PW    = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  logic             sync1_q, sync2_q, edge_q;
  logic             ev;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       prev_q, prev_d;
  logic [PW-1:0]    shadow_q, shadow_d;
  logic [PW-1:0]    payload_q, payload_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             synced_q, synced_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [7:0]       csum;
  logic             bad;

  assign ev = sync2_q & ~edge_q;

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) csum = csum ^ shadow_q[i*8 +: 8];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    shadow_d  = shadow_q;
    payload_d = payload_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    synced_d  = synced_q;
    fcnt_d    = fcnt_q;
    ecnt_d    = ecnt_q;
    bad       = 1'b0;
    if (ev) begin
      case (state_q)
        HUNT: begin
          prev_d = data;
          if (prev_q == TERM_HI && data == TERM_LO) begin
            state_d  = COLLECT;
            idx_d    = '0;
            synced_d = 1'b1;
          end
        end
        COLLECT: begin
          // first-received byte lands in the most significant slot
          for (int i = 0; i < PAYLOAD_BYTES; i++)
            if (idx_q == IDX_W'(i)) shadow_d[(PAYLOAD_BYTES-1-i)*8 +: 8] = data;
          if (idx_q == LAST_IDX) begin
            state_d = EXP_HI;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        EXP_HI: begin
          if (data == TERM_HI) state_d = EXP_LF;
          else                 bad     = 1'b1;
        end
        default: begin
          if (data == TERM_LO && (!CHECKSUM_EN || csum == 8'h00)) begin
            payload_d = shadow_q;
            valid_d   = 1'b1;
            fcnt_d    = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
            state_d   = COLLECT;
            idx_d     = '0;
          end else begin
            bad = 1'b1;
          end
        end
      endcase
      // keeping the faulty byte lets a TERM_HI error byte start the resync pair
      if (bad) begin
        err_d    = 1'b1;
        ecnt_d   = (ecnt_q == '1) ? ecnt_q : ecnt_q + 1'b1;
        synced_d = 1'b0;
        prev_d   = data;
        state_d  = HUNT;
        idx_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      edge_q    <= 1'b0;
      state_q   <= HUNT;
      idx_q     <= '0;
      prev_q    <= 8'h00;
      shadow_q  <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      synced_q  <= 1'b0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
    end else begin
      sync1_q   <= recieve;
      sync2_q   <= sync1_q;
      edge_q    <= sync2_q;
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      shadow_q  <= shadow_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      synced_q  <= synced_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign payload     = payload_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign synced      = synced_q;
  assign frame_cnt   = fcnt_q;
  assign err_cnt     = ecnt_q;

endmodule
